dlatch_bank_ctrl: RTL and testbench

- Write controller and refresh scheduler for a bank of NUM_REGS dynamic latches, each WIDTH bits wide.
- Arbitrates write access to the bank between two requesters, A and B.
- Each write is a jitter-safe three-phase sequence: data setup, single enable strobe, data hold.
- Periodically rewrites every latch with its own current value, so charge decay never corrupts stored state.

---
 rtl/dlatch_bank_pkg.sv | 19 +
 rtl/dlatch_refresh_timer.sv | 41 ++++
 rtl/dlatch_bank_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_dlatch_bank_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dlatch_bank_pkg.sv
// Shared encodings for the dynamic-latch bank write controller.
package dlatch_bank_pkg;

  // Sequencer states: a write walks IDLE -> SETUP -> STROBE -> HOLD -> IDLE
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;

  // Who owns the sequence currently in flight
  typedef enum logic [1:0] {
    SRC_A   = 2'd0,
    SRC_B   = 2'd1,
    SRC_REF = 2'd2
  } src_e;

endpackage

// File: rtl/dlatch_refresh_timer.sv
// Refresh period counter: raises refresh_pend once per period and flags an
// overrun if the previous request was still unserviced when the next one fell due.
module dlatch_refresh_timer
  import dlatch_bank_pkg::*;
#(
  parameter int REFRESH_PERIOD = 64
) (
  input  logic CLK,
  input  logic n_RES,
  input  logic refresh_taken,
  output logic refresh_pend,
  output logic refresh_miss
);

  localparam int CW = $clog2(REFRESH_PERIOD);

  logic [CW-1:0] cnt_r;
  logic          pend_r;
  logic          miss_r;

  // Period counter with pending/overrun bookkeeping; a wrap always wins over a take
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      cnt_r  <= {CW{1'b0}};
      pend_r <= 1'b0;
      miss_r <= 1'b0;
    end else if (cnt_r == CW'(REFRESH_PERIOD - 1)) begin
      cnt_r  <= {CW{1'b0}};
      pend_r <= 1'b1;
      miss_r <= miss_r | (pend_r & ~refresh_taken);
    end else begin
      cnt_r  <= cnt_r + CW'(1);
      pend_r <= pend_r & ~refresh_taken;
      miss_r <= miss_r;
    end
  end

  assign refresh_pend = pend_r;
  assign refresh_miss = miss_r;

endmodule

// File: rtl/dlatch_bank_ctrl.sv
// Write controller for a bank of dynamic latches: arbitrates two requesters
// and periodic self-refresh, and drives each write as setup / strobe / hold.
module dlatch_bank_ctrl
  import dlatch_bank_pkg::*;
#(
  parameter int NUM_REGS       = 8,
  parameter int WIDTH          = 8,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic                        CLK,
  input  logic                        n_RES,
  input  logic                        req_a,
  input  logic [$clog2(NUM_REGS)-1:0] addr_a,
  input  logic [WIDTH-1:0]            data_a,
  output logic                        ack_a,
  input  logic                        req_b,
  input  logic [$clog2(NUM_REGS)-1:0] addr_b,
  input  logic [WIDTH-1:0]            data_b,
  output logic                        ack_b,
  input  logic [NUM_REGS*WIDTH-1:0]   lat_q,
  output logic [WIDTH-1:0]            lat_d,
  output logic [NUM_REGS-1:0]         lat_en,
  output logic                        busy,
  output logic                        refresh_miss
);

  localparam int AW = $clog2(NUM_REGS);

  state_e              state_r;
  src_e                src_r;
  src_e                rr_last_r;
  logic [AW-1:0]       tgt_r;
  logic [AW-1:0]       ref_ptr_r;
  logic [WIDTH-1:0]    lat_d_r;
  logic [NUM_REGS-1:0] lat_en_r;
  logic                ack_a_r;
  logic                ack_b_r;
  logic                busy_r;

  logic                refresh_pend_s;
  logic                grant_ref_s;
  logic                grant_a_s;
  logic                grant_b_s;
  logic [WIDTH-1:0]    ref_data_s;
  logic [NUM_REGS-1:0] en_dec_s;

  dlatch_refresh_timer #(
    .REFRESH_PERIOD(REFRESH_PERIOD)
  ) u_timer (
    .CLK          (CLK),
    .n_RES        (n_RES),
    .refresh_taken(grant_ref_s),
    .refresh_pend (refresh_pend_s),
    .refresh_miss (refresh_miss)
  );

  // Arbitration in IDLE: refresh first, then round-robin, then a lone requester
  always_comb begin
    grant_ref_s = 1'b0;
    grant_a_s   = 1'b0;
    grant_b_s   = 1'b0;
    if (state_r == IDLE) begin
      if (refresh_pend_s) begin
        grant_ref_s = 1'b1;
      end else if (req_a && req_b) begin
        if (rr_last_r == SRC_B) begin
          grant_a_s = 1'b1;
        end else begin
          grant_b_s = 1'b1;
        end
      end else if (req_a) begin
        grant_a_s = 1'b1;
      end else if (req_b) begin
        grant_b_s = 1'b1;
      end else begin
        grant_a_s = 1'b0;
      end
    end else begin
      grant_ref_s = 1'b0;
    end
  end

  // Current contents of the register the refresh pointer addresses
  always_comb begin
    ref_data_s = lat_q[int'(ref_ptr_r)*WIDTH +: WIDTH];
  end

  // One-hot strobe decode; an out-of-range target decodes to no strobe at all
  always_comb begin
    en_dec_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (int'(tgt_r) == i) begin
        en_dec_s[i] = 1'b1;
      end else begin
        en_dec_s[i] = 1'b0;
      end
    end
  end

  // Write sequencer with capture registers, round-robin memory and refresh pointer
  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      state_r   <= IDLE;
      src_r     <= SRC_A;
      rr_last_r <= SRC_B;
      tgt_r     <= {AW{1'b0}};
      ref_ptr_r <= {AW{1'b0}};
      lat_d_r   <= {WIDTH{1'b0}};
      lat_en_r  <= {NUM_REGS{1'b0}};
      ack_a_r   <= 1'b0;
      ack_b_r   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          lat_en_r <= {NUM_REGS{1'b0}};
          ack_a_r  <= 1'b0;
          ack_b_r  <= 1'b0;
          if (grant_ref_s) begin
            state_r <= SETUP;
            busy_r  <= 1'b1;
            src_r   <= SRC_REF;
            tgt_r   <= ref_ptr_r;
            lat_d_r <= ref_data_s;
          end else if (grant_a_s) begin
            state_r   <= SETUP;
            busy_r    <= 1'b1;
            src_r     <= SRC_A;
            rr_last_r <= SRC_A;
            tgt_r     <= addr_a;
            lat_d_r   <= data_a;
          end else if (grant_b_s) begin
            state_r   <= SETUP;
            busy_r    <= 1'b1;
            src_r     <= SRC_B;
            rr_last_r <= SRC_B;
            tgt_r     <= addr_b;
            lat_d_r   <= data_b;
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        SETUP: begin
          state_r  <= STROBE;
          lat_en_r <= en_dec_s;
        end
        STROBE: begin
          state_r  <= HOLD;
          lat_en_r <= {NUM_REGS{1'b0}};
          ack_a_r  <= (src_r == SRC_A);
          ack_b_r  <= (src_r == SRC_B);
        end
        HOLD: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          ack_a_r <= 1'b0;
          ack_b_r <= 1'b0;
          if (src_r == SRC_REF) begin
            if (ref_ptr_r == AW'(NUM_REGS - 1)) begin
              ref_ptr_r <= {AW{1'b0}};
            end else begin
              ref_ptr_r <= ref_ptr_r + AW'(1);
            end
          end else begin
            ref_ptr_r <= ref_ptr_r;
          end
        end
        default: begin
          state_r  <= IDLE;
          busy_r   <= 1'b0;
          lat_en_r <= {NUM_REGS{1'b0}};
          ack_a_r  <= 1'b0;
          ack_b_r  <= 1'b0;
        end
      endcase
    end
  end

  assign lat_d  = lat_d_r;
  assign lat_en = lat_en_r;
  assign ack_a  = ack_a_r;
  assign ack_b  = ack_b_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_dlatch_bank_ctrl.sv
// Bench for dlatch_bank_ctrl: a behavioural latch bank plus directed and
// randomized writes, checked against a memory model and cycle-count predictions.
module tb_dlatch_bank_ctrl;

  logic        clk;
  logic        n_RES;
  logic        req_a, req_b;
  logic [2:0]  addr_a, addr_b;
  logic [7:0]  data_a, data_b;
  logic        ack_a, ack_b;
  logic [63:0] lat_q;
  logic [7:0]  lat_d;
  logic [7:0]  lat_en;
  logic        busy, refresh_miss;

  logic        tm_taken, tm_pend, tm_miss;

  logic [7:0]  bank [8];
  logic [7:0]  want_mem [8];
  logic [7:0]  prev_d;
  int          total = 0;
  int          bad = 0;
  int          en_seen;
  int          acks_a, acks_b;

  dlatch_bank_ctrl #(.NUM_REGS(8), .WIDTH(8), .REFRESH_PERIOD(64)) dut (
    .CLK(clk), .n_RES(n_RES),
    .req_a(req_a), .addr_a(addr_a), .data_a(data_a), .ack_a(ack_a),
    .req_b(req_b), .addr_b(addr_b), .data_b(data_b), .ack_b(ack_b),
    .lat_q(lat_q), .lat_d(lat_d), .lat_en(lat_en),
    .busy(busy), .refresh_miss(refresh_miss)
  );

  // Short-period timer whose take input is under bench control, to provoke overrun
  dlatch_refresh_timer #(.REFRESH_PERIOD(8)) u_tm (
    .CLK(clk), .n_RES(n_RES), .refresh_taken(tm_taken),
    .refresh_pend(tm_pend), .refresh_miss(tm_miss)
  );

  always #5 clk = ~clk;

  // Latch outputs presented to the controller
  always_comb begin
    for (int i = 0; i < 8; i++) lat_q[i*8 +: 8] = bank[i];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Advance to the next falling edge, check bus invariants, and let strobed latches follow lat_d
  task automatic tick();
    @(negedge clk);
    chk("en_onehot0", 32'($onehot0(lat_en)), 32'd1);
    if (lat_en != 8'h00) chk("d_stable_under_en", 32'(lat_d), 32'(prev_d));
    for (int i = 0; i < 8; i++) if (lat_en[i]) bank[i] = lat_d;
    prev_d = lat_d;
  endtask

  task automatic do_reset();
    n_RES = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;
    tick();
    tick();
    n_RES = 1'b1;
  endtask

  initial begin
    clk = 1'b0; n_RES = 1'b0; tm_taken = 1'b0;
    req_a = 1'b0; req_b = 1'b0;
    addr_a = 3'd0; addr_b = 3'd0; data_a = 8'h00; data_b = 8'h00;
    prev_d = 8'h00;
    for (int i = 0; i < 8; i++) bank[i] = 8'($urandom);

    // Reset values
    tick();
    chk("rst_lat_en", 32'(lat_en), 32'h0);
    chk("rst_lat_d", 32'(lat_d), 32'h0);
    chk("rst_ack_a", 32'(ack_a), 32'h0);
    chk("rst_ack_b", 32'(ack_b), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_miss", 32'(refresh_miss), 32'h0);
    n_RES = 1'b1;

    // Single write A: reg3 <= A5
    req_a = 1'b1; addr_a = 3'd3; data_a = 8'hA5;
    tick();
    chk("w1_setup_busy", 32'(busy), 32'h1);
    chk("w1_setup_d", 32'(lat_d), 32'hA5);
    chk("w1_setup_en", 32'(lat_en), 32'h0);
    tick();
    chk("w1_strobe_en", 32'(lat_en), 32'h08);
    chk("w1_strobe_ack", 32'(ack_a), 32'h0);
    tick();
    chk("w1_hold_ack", 32'(ack_a), 32'h1);
    chk("w1_hold_en", 32'(lat_en), 32'h0);
    req_a = 1'b0;
    tick();
    chk("w1_idle_busy", 32'(busy), 32'h0);
    chk("w1_idle_ack", 32'(ack_a), 32'h0);
    chk("w1_bank3", 32'(bank[3]), 32'hA5);

    // Contention: both held; a full slot is grant + setup + strobe + hold
    do_reset();
    req_a = 1'b1; addr_a = 3'd1; data_a = 8'h11;
    req_b = 1'b1; addr_b = 3'd2; data_b = 8'h22;
    for (int t = 1; t <= 16; t++) begin
      tick();
      chk($sformatf("rr_ack_a_t%0d", t), 32'(ack_a), 32'(t == 3 || t == 11));
      chk($sformatf("rr_ack_b_t%0d", t), 32'(ack_b), 32'(t == 7 || t == 15));
      if (t % 4 == 2) chk($sformatf("rr_en_t%0d", t), 32'(lat_en), (t % 8 == 2) ? 32'h02 : 32'h04);
      if (ack_a) data_a = data_a + 8'h01;
      if (ack_b) data_b = data_b + 8'h01;
    end
    req_a = 1'b0; req_b = 1'b0;
    chk("rr_bank1", 32'(bank[1]), 32'h12);
    chk("rr_bank2", 32'(bank[2]), 32'h23);

    // Refresh with no traffic: one strobe per period, pointer walks upward
    do_reset();
    bank[0] = 8'h5A;
    en_seen = 0;
    for (int t = 1; t <= 130; t++) begin
      tick();
      if (lat_en != 8'h00) en_seen++;
      if (t == 66) begin
        chk("ref0_en", 32'(lat_en), 32'h01);
        chk("ref0_d", 32'(lat_d), 32'h5A);
      end
      if (t == 130) begin
        chk("ref1_en", 32'(lat_en), 32'h02);
        chk("ref1_d", 32'(lat_d), 32'(bank[1]));
      end
      if (t == 67) chk("ref0_noack", 32'(ack_a | ack_b), 32'h0);
    end
    chk("ref_strobe_count", 32'(en_seen), 32'd2);
    chk("ref_bank0_kept", 32'(bank[0]), 32'h5A);

    // Refresh priority: B arrives while refresh pending, loses one full slot
    do_reset();
    for (int t = 1; t <= 64; t++) tick();
    req_b = 1'b1; addr_b = 3'd6; data_b = 8'hC3;
    for (int t = 65; t <= 72; t++) begin
      tick();
      chk($sformatf("prio_ack_b_t%0d", t), 32'(ack_b), 32'(t == 71));
      if (t == 66) chk("prio_ref_en", 32'(lat_en), 32'h01);
      if (t == 70) chk("prio_b_en", 32'(lat_en), 32'h40);
      if (ack_b) req_b = 1'b0;
    end

    // Wrap coincides with B's grant: refresh follows in the next IDLE
    do_reset();
    for (int t = 1; t <= 63; t++) tick();
    req_b = 1'b1; addr_b = 3'd5; data_b = 8'h3C;
    for (int t = 64; t <= 70; t++) begin
      tick();
      if (t == 65) chk("coin_b_en", 32'(lat_en), 32'h20);
      if (t == 66) chk("coin_ack_b", 32'(ack_b), 32'h1);
      if (t == 69) begin
        chk("coin_ref_en", 32'(lat_en), 32'h01);
        chk("coin_ref_d", 32'(lat_d), 32'(bank[0]));
      end
      if (ack_b) req_b = 1'b0;
    end

    // Overrun on the bench-controlled timer: never taken -> miss on second wrap
    do_reset();
    for (int t = 1; t <= 31; t++) begin
      tick();
      if (t == 7) chk("tm_pend_pre", 32'(tm_pend), 32'h0);
      if (t == 8) begin
        chk("tm_pend_wrap", 32'(tm_pend), 32'h1);
        chk("tm_miss_first", 32'(tm_miss), 32'h0);
      end
      if (t == 15) chk("tm_miss_before", 32'(tm_miss), 32'h0);
      if (t == 16) chk("tm_miss_set", 32'(tm_miss), 32'h1);
      if (t == 30) begin
        chk("tm_miss_sticky", 32'(tm_miss), 32'h1);
        tm_taken = 1'b1;
      end
      if (t == 31) begin
        chk("tm_take_clears", 32'(tm_pend), 32'h0);
        chk("tm_miss_after_take", 32'(tm_miss), 32'h1);
        tm_taken = 1'b0;
      end
    end
    do_reset();
    chk("tm_miss_cleared", 32'(tm_miss), 32'h0);

    // Randomized traffic from both requesters against a memory model
    do_reset();
    for (int i = 0; i < 8; i++) want_mem[i] = bank[i];
    acks_a = 0; acks_b = 0;
    for (int t = 1; t <= 330; t++) begin
      tick();
      if (ack_a) begin
        chk("rnd_ack_a_req", 32'(req_a), 32'h1);
        want_mem[addr_a] = data_a;
        acks_a++;
        req_a = 1'b0;
      end
      if (ack_b) begin
        chk("rnd_ack_b_req", 32'(req_b), 32'h1);
        want_mem[addr_b] = data_b;
        acks_b++;
        req_b = 1'b0;
      end
      if (t < 300) begin
        if (!req_a && $urandom_range(0, 3) != 0) begin
          req_a = 1'b1; addr_a = 3'($urandom_range(0, 7)); data_a = 8'($urandom);
        end
        if (!req_b && $urandom_range(0, 3) != 0) begin
          req_b = 1'b1; addr_b = 3'($urandom_range(0, 7)); data_b = 8'($urandom);
        end
      end
      if (t == 322) begin
        chk("rnd_ref4_en", 32'(lat_en), 32'h10);
        chk("rnd_ref4_d", 32'(lat_d), 32'(want_mem[4]));
      end
    end
    chk("rnd_no_miss", 32'(refresh_miss), 32'h0);
    chk("rnd_acks_a_seen", 32'(acks_a > 10), 32'h1);
    chk("rnd_acks_b_seen", 32'(acks_b > 10), 32'h1);
    for (int i = 0; i < 8; i++) chk($sformatf("rnd_bank%0d", i), 32'(bank[i]), 32'(want_mem[i]));

    // Reset during STROBE: strobe drops at once, no ack, pointer back to 0
    req_a = 1'b1; addr_a = 3'd5; data_a = 8'h77;
    tick();
    tick();
    chk("rm_strobe_en", 32'(lat_en), 32'h20);
    n_RES = 1'b0;
    #1;
    chk("rm_async_en", 32'(lat_en), 32'h0);
    chk("rm_async_ack", 32'(ack_a), 32'h0);
    chk("rm_async_busy", 32'(busy), 32'h0);
    req_a = 1'b0;
    tick();
    tick();
    n_RES = 1'b1;
    for (int t = 1; t <= 66; t++) begin
      tick();
      if (t <= 4) chk($sformatf("rm_noack_t%0d", t), 32'(ack_a), 32'h0);
      if (t == 1) chk("rm_busy_idle", 32'(busy), 32'h0);
      if (t == 66) chk("rm_ptr_zero", 32'(lat_en), 32'h01);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
